// File: rtl/mem_wb_stage_if.sv
// Data-memory request/acknowledge bus between the MEM stage and data memory.
// The pipeline side uses the master modport, the memory model the slave one.
interface mem_wb_stage_if;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
    input  mem_ack, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
    output mem_ack, mem_rdata
  );
endinterface

// File: rtl/mem_wb_stage.sv
// RV32 memory-access and write-back stage.
// Issues loads/stores on a req/ack bus, aligns store lanes and load data,
// stalls upstream while an access is outstanding, aborts on timeout, and
// registers the MEM/WB boundary feeding the register file.
module mem_wb_stage #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                  CLK,
  input  logic                  rst,
  input  logic                  RegWriteM,
  input  logic                  MemReadM,
  input  logic                  MemWriteM,
  input  logic [1:0]            ResultSrcM,
  input  logic [2:0]            Funct3M,
  input  logic [4:0]            RD_M,
  input  logic [31:0]           ALU_ResultM,
  input  logic [31:0]           WriteDataM,
  input  logic [31:0]           PCPlus4M,
  mem_wb_stage_if.master        bus,
  output logic                  StallM,
  output logic                  RegWriteW,
  output logic [4:0]            RDW,
  output logic [31:0]           ResultW,
  output logic                  MisalignErr,
  output logic                  BusErr
);

  localparam logic [7:0] TIMEOUT_W = 8'(TIMEOUT_CYCLES);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

  // Replicate store data across byte lanes according to access size.
  function automatic logic [31:0] store_data(input logic [1:0] size, input logic [31:0] d);
    logic [31:0] r;
    case (size)
      2'b00:   r = {4{d[7:0]}};
      2'b01:   r = {2{d[15:0]}};
      default: r = d;
    endcase
    return r;
  endfunction

  // Byte enables for a store of the given size at the given byte offset.
  function automatic logic [3:0] store_strb(input logic [1:0] size, input logic [1:0] off);
    logic [3:0] r;
    case (size)
      2'b00:   r = 4'b0001 << off;
      2'b01:   r = 4'b0011 << off;
      2'b10:   r = 4'b1111;
      default: r = 4'b0000;
    endcase
    return r;
  endfunction

  // Select and extend the addressed byte/half of a read word.
  function automatic logic [31:0] load_extract(input logic [2:0] f3, input logic [1:0] off,
                                               input logic [31:0] w);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (off)
      2'd0:    b = w[7:0];
      2'd1:    b = w[15:8];
      2'd2:    b = w[23:16];
      default: b = w[31:24];
    endcase
    h = off[1] ? w[31:16] : w[15:0];
    case (f3)
      3'b000:  r = {{24{b[7]}}, b};
      3'b001:  r = {{16{h[15]}}, h};
      3'b010:  r = w;
      3'b100:  r = {24'h000000, b};
      3'b101:  r = {16'h0000, h};
      default: r = 32'h0000_0000;
    endcase
    return r;
  endfunction

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [31:0] req_addr_q, req_addr_d;
  logic [1:0]  req_off_q, req_off_d;
  logic        req_we_q, req_we_d;
  logic [31:0] req_wdata_q, req_wdata_d;
  logic [3:0]  req_wstrb_q, req_wstrb_d;
  logic [2:0]  req_f3_q, req_f3_d;
  logic [4:0]  req_rd_q, req_rd_d;
  logic        req_rw_q, req_rw_d;

  logic        regwrite_w_q;
  logic [4:0]  rd_w_q;
  logic [31:0] result_w_q;
  logic        misalign_q;
  logic        buserr_q;

  logic        access_s, f3_ok_s, align_ok_s, fault_s, issue_s;
  logic [1:0]  off_s;
  logic        stall_s, misalign_s, timeout_s;
  logic        wb_rw_s, wb_fault_s;
  logic [4:0]  wb_rd_s;
  logic [2:0]  wb_f3_s;
  logic [1:0]  wb_off_s;
  logic [31:0] result_s;

  // Decode the incoming access and classify it as valid or faulting.
  always_comb begin
    access_s = MemReadM | MemWriteM;
    off_s    = ALU_ResultM[1:0];
    if (MemWriteM) begin
      f3_ok_s = (Funct3M == 3'b000) || (Funct3M == 3'b001) || (Funct3M == 3'b010);
    end else begin
      f3_ok_s = (Funct3M == 3'b000) || (Funct3M == 3'b001) || (Funct3M == 3'b010) ||
                (Funct3M == 3'b100) || (Funct3M == 3'b101);
    end
    case (Funct3M[1:0])
      2'b01:   align_ok_s = (off_s[0] == 1'b0);
      2'b10:   align_ok_s = (off_s == 2'b00);
      default: align_ok_s = 1'b1;
    endcase
    fault_s = access_s & ~(f3_ok_s & align_ok_s);
    issue_s = access_s & ~fault_s;
  end

  // Bus FSM next state, bus drive, stall and selection of the write-back source.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    req_addr_d    = req_addr_q;
    req_off_d     = req_off_q;
    req_we_d      = req_we_q;
    req_wdata_d   = req_wdata_q;
    req_wstrb_d   = req_wstrb_q;
    req_f3_d      = req_f3_q;
    req_rd_d      = req_rd_q;
    req_rw_d      = req_rw_q;
    bus.mem_req   = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = 32'h0000_0000;
    bus.mem_wdata = 32'h0000_0000;
    bus.mem_wstrb = 4'b0000;
    stall_s       = 1'b0;
    misalign_s    = 1'b0;
    timeout_s     = 1'b0;
    wb_rw_s       = RegWriteM;
    wb_rd_s       = RD_M;
    wb_f3_s       = Funct3M;
    wb_off_s      = off_s;
    wb_fault_s    = fault_s;
    if (rst) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          misalign_s = fault_s;
          if (issue_s) begin
            bus.mem_req   = 1'b1;
            bus.mem_we    = MemWriteM;
            bus.mem_addr  = {ALU_ResultM[31:2], 2'b00};
            bus.mem_wdata = store_data(Funct3M[1:0], WriteDataM);
            bus.mem_wstrb = MemWriteM ? store_strb(Funct3M[1:0], off_s) : 4'b0000;
            if (!bus.mem_ack) begin
              // No zero-wait completion: capture the request and wait in BUSY.
              stall_s     = 1'b1;
              state_d     = ST_BUSY;
              cnt_d       = 8'd1;
              req_addr_d  = {ALU_ResultM[31:2], 2'b00};
              req_off_d   = off_s;
              req_we_d    = MemWriteM;
              req_wdata_d = store_data(Funct3M[1:0], WriteDataM);
              req_wstrb_d = MemWriteM ? store_strb(Funct3M[1:0], off_s) : 4'b0000;
              req_f3_d    = Funct3M;
              req_rd_d    = RD_M;
              req_rw_d    = RegWriteM;
            end else begin
              state_d = ST_IDLE;
            end
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_BUSY: begin
          bus.mem_req   = 1'b1;
          bus.mem_we    = req_we_q;
          bus.mem_addr  = req_addr_q;
          bus.mem_wdata = req_wdata_q;
          bus.mem_wstrb = req_wstrb_q;
          wb_rw_s       = req_rw_q;
          wb_rd_s       = req_rd_q;
          wb_f3_s       = req_f3_q;
          wb_off_s      = req_off_q;
          wb_fault_s    = 1'b0;
          if (bus.mem_ack) begin
            state_d = ST_IDLE;
            cnt_d   = 8'd0;
          end else if (cnt_q == TIMEOUT_W) begin
            // Abort: release upstream now, suppress write-back, flag BusErr.
            state_d    = ST_IDLE;
            cnt_d      = 8'd0;
            timeout_s  = 1'b1;
            wb_fault_s = 1'b1;
          end else begin
            stall_s = 1'b1;
            cnt_d   = cnt_q + 8'd1;
          end
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = 8'd0;
        end
      endcase
    end
  end

  // Write-back data mux: load data, link value, or ALU result.
  always_comb begin
    case (ResultSrcM)
      2'b01:   result_s = load_extract(wb_f3_s, wb_off_s, bus.mem_rdata);
      2'b10:   result_s = PCPlus4M;
      default: result_s = ALU_ResultM;
    endcase
  end

  // FSM state, timeout counter and latched request copy.
  always_ff @(posedge CLK) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 8'd0;
      req_addr_q  <= 32'h0000_0000;
      req_off_q   <= 2'b00;
      req_we_q    <= 1'b0;
      req_wdata_q <= 32'h0000_0000;
      req_wstrb_q <= 4'b0000;
      req_f3_q    <= 3'b000;
      req_rd_q    <= 5'd0;
      req_rw_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      req_addr_q  <= req_addr_d;
      req_off_q   <= req_off_d;
      req_we_q    <= req_we_d;
      req_wdata_q <= req_wdata_d;
      req_wstrb_q <= req_wstrb_d;
      req_f3_q    <= req_f3_d;
      req_rd_q    <= req_rd_d;
      req_rw_q    <= req_rw_d;
    end
  end

  // MEM/WB boundary: bubble on stall, otherwise capture the completed instruction.
  always_ff @(posedge CLK) begin
    if (rst) begin
      regwrite_w_q <= 1'b0;
      rd_w_q       <= 5'd0;
      result_w_q   <= 32'h0000_0000;
      misalign_q   <= 1'b0;
      buserr_q     <= 1'b0;
    end else begin
      misalign_q <= misalign_s;
      buserr_q   <= timeout_s;
      if (stall_s) begin
        regwrite_w_q <= 1'b0;
      end else begin
        regwrite_w_q <= wb_rw_s & (wb_rd_s != 5'd0) & ~wb_fault_s;
        rd_w_q       <= wb_rd_s;
        result_w_q   <= result_s;
      end
    end
  end

  assign StallM      = stall_s;
  assign RegWriteW   = regwrite_w_q;
  assign RDW         = rd_w_q;
  assign ResultW     = result_w_q;
  assign MisalignErr = misalign_q;
  assign BusErr      = buserr_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Self-checking bench for mem_wb_stage: per-cycle vector records carry the
// inputs, expected bus/stall values and the expected write-back; write-back
// expectations go through a scoreboard queue and are popped one cycle later.
module tb_mem_wb_stage;

  logic        CLK = 1'b0;
  logic        rst;
  logic        RegWriteM, MemReadM, MemWriteM;
  logic [1:0]  ResultSrcM;
  logic [2:0]  Funct3M;
  logic [4:0]  RD_M;
  logic [31:0] ALU_ResultM, WriteDataM, PCPlus4M;
  logic        StallM, RegWriteW, MisalignErr, BusErr;
  logic [4:0]  RDW;
  logic [31:0] ResultW;

  mem_wb_stage_if bus ();

  mem_wb_stage #(.TIMEOUT_CYCLES(4)) dut (
    .CLK(CLK), .rst(rst), .RegWriteM(RegWriteM), .MemReadM(MemReadM), .MemWriteM(MemWriteM),
    .ResultSrcM(ResultSrcM), .Funct3M(Funct3M), .RD_M(RD_M), .ALU_ResultM(ALU_ResultM),
    .WriteDataM(WriteDataM), .PCPlus4M(PCPlus4M), .bus(bus), .StallM(StallM),
    .RegWriteW(RegWriteW), .RDW(RDW), .ResultW(ResultW), .MisalignErr(MisalignErr), .BusErr(BusErr)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic rst, rw, mr, mw; logic [1:0] rs; logic [2:0] f3; logic [4:0] rd;
    logic [31:0] alu, wd, pc4; logic ack; logic [31:0] rdata;
    logic e_req, e_we; logic [31:0] e_addr, e_wdata; logic [3:0] e_wstrb; logic e_stall;
    logic e_rw; logic [4:0] e_rd; logic [31:0] e_res; logic e_mis, e_bus, e_chk;
  } vec_t;

  typedef struct {
    logic rw; logic [4:0] rd; logic [31:0] res; logic mis, bus, chk;
  } wexp_t;

  wexp_t       sb[$];
  int          total = 0;
  int          bad = 0;
  logic [4:0]  hold_rd = 5'd0;
  logic [31:0] hold_res = 32'h0;

  function automatic vec_t op(input logic rw, mr, mw, input logic [1:0] rs, input logic [2:0] f3,
                              input logic [4:0] rd, input logic [31:0] alu, wd, pc4,
                              input logic ack, input logic [31:0] rdata);
    vec_t v = '{default: '0};
    v.rw = rw; v.mr = mr; v.mw = mw; v.rs = rs; v.f3 = f3; v.rd = rd;
    v.alu = alu; v.wd = wd; v.pc4 = pc4; v.ack = ack; v.rdata = rdata; v.e_chk = 1'b1;
    return v;
  endfunction

  function automatic vec_t ec(input vec_t vi, input logic req, we, input logic [31:0] addr, wdata,
                              input logic [3:0] wstrb, input logic stall);
    vec_t v = vi;
    v.e_req = req; v.e_we = we; v.e_addr = addr; v.e_wdata = wdata; v.e_wstrb = wstrb; v.e_stall = stall;
    return v;
  endfunction

  function automatic vec_t ew(input vec_t vi, input logic rw, input logic [4:0] rd,
                              input logic [31:0] res, input logic mis, bus);
    vec_t v = vi;
    v.e_rw = rw; v.e_rd = rd; v.e_res = res; v.e_mis = mis; v.e_bus = bus;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One clock: drive, check bus/stall, push write-back expectation, check it after the edge.
  task automatic run(input vec_t v, input string tag);
    wexp_t w;
    @(negedge CLK);
    rst = v.rst; RegWriteM = v.rw; MemReadM = v.mr; MemWriteM = v.mw; ResultSrcM = v.rs;
    Funct3M = v.f3; RD_M = v.rd; ALU_ResultM = v.alu; WriteDataM = v.wd; PCPlus4M = v.pc4;
    bus.mem_ack = v.ack; bus.mem_rdata = v.rdata;
    #1;
    chk({tag, " mem_req"}, {31'd0, bus.mem_req}, {31'd0, v.e_req});
    chk({tag, " StallM"}, {31'd0, StallM}, {31'd0, v.e_stall});
    if (v.e_req) begin
      chk({tag, " mem_addr"}, bus.mem_addr, v.e_addr);
      chk({tag, " mem_we"}, {31'd0, bus.mem_we}, {31'd0, v.e_we});
      chk({tag, " mem_wstrb"}, {28'd0, bus.mem_wstrb}, {28'd0, v.e_wstrb});
      if (v.e_we) chk({tag, " mem_wdata"}, bus.mem_wdata, v.e_wdata);
    end
    if (v.e_stall) begin
      w = '{rw: 1'b0, rd: hold_rd, res: hold_res, mis: 1'b0, bus: 1'b0, chk: 1'b1};
    end else begin
      w = '{rw: v.e_rw, rd: v.e_rd, res: v.e_res, mis: v.e_mis, bus: v.e_bus, chk: v.e_chk};
      hold_rd = v.e_rd; hold_res = v.e_res;
    end
    sb.push_back(w);
    @(posedge CLK);
    #1;
    w = sb.pop_front();
    chk({tag, " RegWriteW"}, {31'd0, RegWriteW}, {31'd0, w.rw});
    chk({tag, " MisalignErr"}, {31'd0, MisalignErr}, {31'd0, w.mis});
    chk({tag, " BusErr"}, {31'd0, BusErr}, {31'd0, w.bus});
    if (w.chk) begin
      chk({tag, " RDW"}, {27'd0, RDW}, {27'd0, w.rd});
      chk({tag, " ResultW"}, ResultW, w.res);
    end
  endtask

  vec_t tbl[16];
  vec_t v, nop_v;

  initial begin
    rst = 1'b1; RegWriteM = 1'b0; MemReadM = 1'b0; MemWriteM = 1'b0; ResultSrcM = 2'b00;
    Funct3M = 3'b000; RD_M = 5'd0; ALU_ResultM = 32'h0; WriteDataM = 32'h0; PCPlus4M = 32'h0;
    bus.mem_ack = 1'b0; bus.mem_rdata = 32'h0;

    nop_v = op(1'b0, 1'b0, 1'b0, 2'b00, 3'b000, 5'd0, 32'h0, 32'h0, 32'h0, 1'b0, 32'h0);

    // rw mr mw rs f3 rd alu wd pc4 ack rdata
    tbl[0]  = nop_v; tbl[0].rst = 1'b1;
    tbl[1]  = ew(op(1, 0, 0, 2'b00, 3'b000, 5'd3, 32'h1234_5678, 32'h0, 32'h0, 0, 32'h0),
                 1, 5'd3, 32'h1234_5678, 0, 0);
    tbl[2]  = ew(op(1, 0, 0, 2'b00, 3'b000, 5'd0, 32'h0000_0055, 32'h0, 32'h0, 0, 32'h0),
                 0, 5'd0, 32'h0000_0055, 0, 0);
    tbl[3]  = ew(op(1, 0, 0, 2'b10, 3'b000, 5'd1, 32'h0000_0099, 32'h0, 32'h0000_0044, 0, 32'h0),
                 1, 5'd1, 32'h0000_0044, 0, 0);
    tbl[4]  = ew(op(1, 0, 0, 2'b11, 3'b000, 5'd7, 32'h0000_0077, 32'h0, 32'h0000_0010, 0, 32'h0),
                 1, 5'd7, 32'h0000_0077, 0, 0);
    tbl[5]  = ew(ec(op(1, 1, 0, 2'b01, 3'b010, 5'd5, 32'h0000_0100, 32'h0, 32'h0, 1, 32'hDEAD_BEEF),
                    1, 0, 32'h0000_0100, 32'h0, 4'b0000, 0), 1, 5'd5, 32'hDEAD_BEEF, 0, 0);
    tbl[6]  = ew(ec(op(0, 0, 1, 2'b00, 3'b001, 5'd9, 32'h0000_0012, 32'h0000_ABCD, 32'h0, 1, 32'h0),
                    1, 1, 32'h0000_0010, 32'hABCD_ABCD, 4'b1100, 0), 0, 5'd9, 32'h0000_0012, 0, 0);
    tbl[7]  = ew(ec(op(0, 0, 1, 2'b00, 3'b000, 5'd2, 32'h0000_0203, 32'h0000_00A5, 32'h0, 1, 32'h0),
                    1, 1, 32'h0000_0200, 32'hA5A5_A5A5, 4'b1000, 0), 0, 5'd2, 32'h0000_0203, 0, 0);
    tbl[8]  = ew(ec(op(0, 0, 1, 2'b00, 3'b010, 5'd4, 32'h0000_0040, 32'h1234_5678, 32'h0, 1, 32'h0),
                    1, 1, 32'h0000_0040, 32'h1234_5678, 4'b1111, 0), 0, 5'd4, 32'h0000_0040, 0, 0);
    tbl[9]  = ew(op(1, 1, 0, 2'b01, 3'b010, 5'd5, 32'h0000_0102, 32'h0, 32'h0, 0, 32'h0),
                 0, 5'd5, 32'h0, 1, 0);
    tbl[10] = ew(op(1, 1, 0, 2'b01, 3'b011, 5'd5, 32'h0000_0100, 32'h0, 32'h0, 0, 32'h0),
                 0, 5'd5, 32'h0, 1, 0);
    tbl[11] = ew(op(1, 1, 0, 2'b01, 3'b001, 5'd6, 32'h0000_0101, 32'h0, 32'h0, 0, 32'h0),
                 0, 5'd6, 32'h0, 1, 0);
    tbl[12] = ew(ec(op(1, 1, 0, 2'b01, 3'b101, 5'd10, 32'h0000_0106, 32'h0, 32'h0, 1, 32'h8001_7FFF),
                    1, 0, 32'h0000_0104, 32'h0, 4'b0000, 0), 1, 5'd10, 32'h0000_8001, 0, 0);
    tbl[13] = ew(ec(op(1, 1, 0, 2'b01, 3'b001, 5'd11, 32'h0000_0104, 32'h0, 32'h0, 1, 32'h0000_8123),
                    1, 0, 32'h0000_0104, 32'h0, 4'b0000, 0), 1, 5'd11, 32'hFFFF_8123, 0, 0);
    tbl[14] = ew(ec(op(1, 1, 0, 2'b01, 3'b000, 5'd12, 32'h0000_0201, 32'h0, 32'h0, 1, 32'h0000_7F00),
                    1, 0, 32'h0000_0200, 32'h0, 4'b0000, 0), 1, 5'd12, 32'h0000_007F, 0, 0);
    tbl[15] = ew(op(0, 0, 1, 2'b00, 3'b100, 5'd0, 32'h0000_0300, 32'h1, 32'h0, 0, 32'h0),
                 0, 5'd0, 32'h0000_0300, 1, 0);

    for (int i = 0; i < 16; i++) run(tbl[i], $sformatf("vec%0d", i));

    // LB / LBU at 0x203 with three wait cycles; address perturbed while busy.
    for (int k = 0; k < 2; k++) begin
      logic [2:0]  f3;
      logic [31:0] exp_res;
      f3      = (k == 0) ? 3'b000 : 3'b100;
      exp_res = (k == 0) ? 32'hFFFF_FF80 : 32'h0000_0080;
      v = ec(op(1, 1, 0, 2'b01, f3, 5'd8, 32'h0000_0203, 32'h0, 32'h0, 0, 32'h0),
             1, 0, 32'h0000_0200, 32'h0, 4'b0000, 1);
      run(v, $sformatf("lbwait%0d_c0", k));
      v.alu = 32'hFFFF_FFF0;
      run(v, $sformatf("lbwait%0d_c1", k));
      run(v, $sformatf("lbwait%0d_c2", k));
      v.ack = 1'b1; v.rdata = 32'h8011_2233; v.e_stall = 1'b0;
      v = ew(v, 1, 5'd8, exp_res, 0, 0);
      run(v, $sformatf("lbwait%0d_c3", k));
    end

    // Timeout after four stalled cycles, then a late ack that must be ignored.
    v = ec(op(1, 1, 0, 2'b01, 3'b010, 5'd6, 32'h0000_0300, 32'h0, 32'h0, 0, 32'h0),
           1, 0, 32'h0000_0300, 32'h0, 4'b0000, 1);
    for (int c = 0; c < 4; c++) run(v, $sformatf("tmo_c%0d", c));
    v.e_stall = 1'b0;
    v = ew(v, 0, 5'd6, 32'h0, 0, 1);
    v.e_chk = 1'b0;
    run(v, "tmo_abort");
    v = nop_v; v.ack = 1'b1;
    run(v, "tmo_lateack");
    run(nop_v, "tmo_after");

    // Reset while BUSY abandons the access.
    run(ew(op(1, 0, 0, 2'b00, 3'b000, 5'd3, 32'h0000_AAAA, 32'h0, 32'h0, 0, 32'h0),
           1, 5'd3, 32'h0000_AAAA, 0, 0), "rstb_alu");
    v = ec(op(1, 1, 0, 2'b01, 3'b010, 5'd4, 32'h0000_0400, 32'h0, 32'h0, 0, 32'h0),
           1, 0, 32'h0000_0400, 32'h0, 4'b0000, 1);
    run(v, "rstb_c0");
    run(v, "rstb_c1");
    v = op(1, 1, 0, 2'b01, 3'b010, 5'd4, 32'h0000_0400, 32'h0, 32'h0, 0, 32'h0);
    v.rst = 1'b1;
    run(v, "rstb_rst");
    v = nop_v; v.ack = 1'b1;
    run(v, "rstb_after");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
